// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexes a double-buffered multi-digit hex value
// onto one shared 7-segment decoder and a common-anode digit bank, with
// optional leading-zero blanking. New values commit only at frame boundaries.
module hex_display_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    output logic [3:0]                nibble,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      blank,
    output logic                      frame_start,
    output logic                      pending
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] shadow_q, shadow_d;
    logic [VW-1:0] active_q, active_d;
    logic          pending_q, pending_d;
    logic          frame_start_q, frame_start_d;

    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] slot_blank;
    logic                  all_zero;

    // Slot timing: prescaler tick and the last-slot tick that closes a frame.
    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == IDX_LAST);
    end

    // Next-state for counters, the shadow/active double buffer and frame_start.
    always_comb begin
        presc_d       = presc_q + PW'(1);
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_start_d = boundary;

        if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        if (load) begin
            shadow_d = value;
        end

        if (boundary) begin
            // A load landing on the boundary goes straight to the display so
            // it is not held back a whole frame behind the shadow.
            if (load) begin
                active_d = value;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Leading-zero mask: slot i blanks when it and every more-significant
    // nibble are zero; digit 0 always shows so a zero value reads "0".
    always_comb begin
        slot_blank = '0;
        all_zero   = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            all_zero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (active_q[4*j +: 4] != 4'h0) begin
                    all_zero = 1'b0;
                end
            end
            slot_blank[i] = BLANK_LEADING && all_zero;
        end
    end

    // Output decode from registered idx/active only.
    always_comb begin
        nibble     = 4'h0;
        digit_en_n = '1;
        blank      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                if (slot_blank[i]) begin
                    blank = 1'b1;
                end else begin
                    nibble        = active_q[4*i +: 4];
                    digit_en_n[i] = 1'b0;
                end
            end
        end
        frame_start = frame_start_q;
        pending     = pending_q;
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed testbench for hex_display_scanner: three instances cover
// 4 digits without blanking, 4 digits with blanking, and 1 digit at full rate.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        load_c;
    logic [3:0]  value_c;

    logic [3:0] nibble_a, nibble_b, nibble_c;
    logic [3:0] en_a, en_b;
    logic [0:0] en_c;
    logic       blank_a, blank_b, blank_c;
    logic       fs_a, fs_b, fs_c;
    logic       pend_a, pend_b, pend_c;

    int checks = 0;
    int errors = 0;

    logic [3:0] en_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_a (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .nibble(nibble_a), .digit_en_n(en_a), .blank(blank_a),
        .frame_start(fs_a), .pending(pend_a));

    hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_b (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .nibble(nibble_b), .digit_en_n(en_b), .blank(blank_b),
        .frame_start(fs_b), .pending(pend_b));

    hex_display_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_c (
        .clk(clk), .reset(reset), .load(load_c), .value(value_c),
        .nibble(nibble_c), .digit_en_n(en_c), .blank(blank_c),
        .frame_start(fs_c), .pending(pend_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int max_cycles);
        int n;
        n = 0;
        step();
        while (fs_a !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (fs_a !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", fs_a, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; load_c = 1'b0; value_c = '0;
        step(); step();
        checks++;
        if ({nibble_a, en_a, blank_a, fs_a, pend_a} !== {4'h0, 4'b1110, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: nib=%h en=%b blank=%b fs=%b pend=%b, required 0 1110 0 0 0",
                     nibble_a, en_a, blank_a, fs_a, pend_a);
        end
        checks++;
        if ({nibble_b, en_b, blank_b, fs_b, pend_b} !== {4'h0, 4'b1110, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: nib=%h en=%b blank=%b fs=%b pend=%b, required 0 1110 0 0 0",
                     nibble_b, en_b, blank_b, fs_b, pend_b);
        end
        checks++;
        if ({nibble_c, en_c, blank_c, fs_c, pend_c} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_c: nib=%h en=%b blank=%b fs=%b pend=%b, required 0 0 0 0 0",
                     nibble_c, en_c, blank_c, fs_c, pend_c);
        end
        reset = 1'b0;
    endtask

    // Load 1A3F at cycle 2; commit at the first boundary (posedge 16).
    task automatic test_basic_scan();
        logic [3:0] exp_nib [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
        step(); step();
        load = 1'b1; value = 16'h1A3F;
        step();
        load = 1'b0;
        checks++;
        if (pend_a !== 1'b1) begin
            errors++; $display("FAIL basic_pending_set: pending=%b, required 1", pend_a);
        end
        repeat (12) step();
        checks++;
        if ({pend_a, fs_a, en_a, nibble_a} !== {1'b1, 1'b0, 4'b0111, 4'h0}) begin
            errors++;
            $display("FAIL basic_pre_boundary: pend=%b fs=%b en=%b nib=%h, required 1 0 0111 0",
                     pend_a, fs_a, en_a, nibble_a);
        end
        step();
        for (int t = 0; t < 16; t++) begin
            if (t > 0) step();
            checks++;
            if (nibble_a !== exp_nib[t/4] || en_a !== en_tab[t/4] || fs_a !== (t == 0) ||
                pend_a !== 1'b0 || blank_a !== 1'b0) begin
                errors++;
                $display("FAIL basic_slot t=%0d: nib=%h en=%b fs=%b pend=%b blank=%b, required %h %b %b 0 0",
                         t, nibble_a, en_a, fs_a, pend_a, blank_a, exp_nib[t/4], en_tab[t/4], (t == 0));
            end
        end
        step();
        checks++;
        if (fs_a !== 1'b1 || en_a !== 4'b1110) begin
            errors++;
            $display("FAIL basic_second_frame: fs=%b en=%b, required 1 1110", fs_a, en_a);
        end
    endtask

    task automatic test_blanking();
        logic [3:0] n40 [4] = '{4'h0, 4'h4, 4'h0, 4'h0};
        logic       b40 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] e40 [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic       b00 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] e00 [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        load = 1'b1; value = 16'h0040;
        step();
        load = 1'b0;
        wait_frame(40);
        for (int t = 0; t < 16; t++) begin
            if (t > 0) step();
            checks++;
            if (nibble_b !== n40[t/4] || blank_b !== b40[t/4] || en_b !== e40[t/4]) begin
                errors++;
                $display("FAIL blank_0040 t=%0d: nib=%h blank=%b en=%b, required %h %b %b",
                         t, nibble_b, blank_b, en_b, n40[t/4], b40[t/4], e40[t/4]);
            end
        end
        step();
        load = 1'b1; value = 16'h0000;
        step();
        load = 1'b0;
        wait_frame(40);
        for (int t = 0; t < 16; t++) begin
            if (t > 0) step();
            checks++;
            if (nibble_b !== 4'h0 || blank_b !== b00[t/4] || en_b !== e00[t/4]) begin
                errors++;
                $display("FAIL blank_0000 t=%0d: nib=%h blank=%b en=%b, required 0 %b %b",
                         t, nibble_b, blank_b, en_b, b00[t/4], e00[t/4]);
            end
        end
    endtask

    // Entered on the boundary cycle (last cycle of slot 3).
    task automatic test_boundary_load();
        logic [3:0] exp_nib [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
        load = 1'b1; value = 16'hBEEF;
        step();
        load = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (t > 0) step();
            checks++;
            if (nibble_a !== exp_nib[t/4] || en_a !== en_tab[t/4] || pend_a !== 1'b0 ||
                fs_a !== (t == 0)) begin
                errors++;
                $display("FAIL boundary_load t=%0d: nib=%h en=%b pend=%b fs=%b, required %h %b 0 %b",
                         t, nibble_a, en_a, pend_a, fs_a, exp_nib[t/4], en_tab[t/4], (t == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] old_nib [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
        step();
        repeat (5) step();
        load = 1'b1; value = 16'h1111;
        step();
        load = 1'b0;
        checks++;
        if (pend_a !== 1'b1) begin
            errors++; $display("FAIL b2b_pending_first: pending=%b, required 1", pend_a);
        end
        repeat (3) step();
        load = 1'b1; value = 16'h2222;
        step();
        load = 1'b0;
        for (int t = 10; t < 16; t++) begin
            if (t > 10) step();
            checks++;
            if (nibble_a !== old_nib[t/4] || pend_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_old_frame t=%0d: nib=%h pend=%b, required %h 1",
                         t, nibble_a, pend_a, old_nib[t/4]);
            end
        end
        step();
        for (int t = 0; t < 16; t++) begin
            if (t > 0) step();
            checks++;
            if (nibble_a !== 4'h2 || en_a !== en_tab[t/4] || pend_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_new_frame t=%0d: nib=%h en=%b pend=%b, required 2 %b 0",
                         t, nibble_a, en_a, pend_a, en_tab[t/4]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        step();
        repeat (8) step();
        load = 1'b1; value = 16'h3333;
        step();
        load = 1'b0;
        checks++;
        if (pend_a !== 1'b1 || en_a !== 4'b1011 || nibble_a !== 4'h2) begin
            errors++;
            $display("FAIL mid_pre_reset: pend=%b en=%b nib=%h, required 1 1011 2", pend_a, en_a, nibble_a);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({en_a, nibble_a, pend_a, fs_a, blank_a} !== {4'b1110, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: en=%b nib=%h pend=%b fs=%b blank=%b, required 1110 0 0 0 0",
                     en_a, nibble_a, pend_a, fs_a, blank_a);
        end
        load = 1'b1; value = 16'h5555;
        step();
        checks++;
        if (pend_a !== 1'b0 || nibble_a !== 4'h0) begin
            errors++;
            $display("FAIL reset_beats_load: pend=%b nib=%h, required 0 0", pend_a, nibble_a);
        end
        reset = 1'b0; load = 1'b0;
        for (int t = 0; t < 32; t++) begin
            step();
            checks++;
            if (nibble_a !== 4'h0 || pend_a !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_stale t=%0d: nib=%h pend=%b, required 0 0", t, nibble_a, pend_a);
            end
        end
    endtask

    task automatic test_single_digit();
        logic [3:0] vals [4] = '{4'h7, 4'hC, 4'h0, 4'h9};
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (fs_c !== 1'b0) begin
            errors++; $display("FAIL single_fs_first: fs=%b, required 0", fs_c);
        end
        step();
        checks++;
        if (fs_c !== 1'b1 || en_c !== 1'b0 || nibble_c !== 4'h0) begin
            errors++;
            $display("FAIL single_idle: fs=%b en=%b nib=%h, required 1 0 0", fs_c, en_c, nibble_c);
        end
        for (int k = 0; k < 4; k++) begin
            load_c = 1'b1; value_c = vals[k];
            step();
            checks++;
            if (nibble_c !== vals[k] || en_c !== 1'b0 || blank_c !== 1'b0 ||
                pend_c !== 1'b0 || fs_c !== 1'b1) begin
                errors++;
                $display("FAIL single_load k=%0d: nib=%h en=%b blank=%b pend=%b fs=%b, required %h 0 0 0 1",
                         k, nibble_c, en_c, blank_c, pend_c, fs_c, vals[k]);
            end
        end
        load_c = 1'b0; value_c = 4'h3;
        step();
        checks++;
        if (nibble_c !== 4'h9 || fs_c !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: nib=%h fs=%b, required 9 1", nibble_c, fs_c);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_blanking();
        test_boundary_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_single_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
